// File: rtl/serial_frame_tx.sv
`default_nettype none
// ============================================================================
// Module   : serial_frame_tx
// Purpose  : Parallel-to-serial frame transmitter. Sends one start bit (0),
//            WIDTH data bits LSB first, an optional parity bit and one stop
//            bit (1). Each bit is held for CLKS_PER_BIT clocks; line idles high.
// Revision : 1.0 - initial release
// ============================================================================
module serial_frame_tx #(
    parameter int WIDTH        = 8,
    parameter int CLKS_PER_BIT = 4,
    parameter int PARITY_EN    = 1,
    parameter int PARITY_ODD   = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] data_in,
    input  logic             valid,
    output logic             ready,
    output logic             tx,
    output logic             busy,
    output logic             done
);

    localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int IDX_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    localparam logic [CNT_W-1:0] C_CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [IDX_W-1:0] C_IDX_LAST = IDX_W'(WIDTH - 1);
    localparam logic             C_PAR_EN   = (PARITY_EN != 0);
    localparam logic             C_PAR_ODD  = (PARITY_ODD != 0);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
        S_PARITY = 3'd3,
        S_STOP   = 3'd4
    } state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q,   cnt_d;
    logic [IDX_W-1:0]   idx_q,   idx_d;
    logic [WIDTH-1:0]   shift_q, shift_d;
    logic               par_q,   par_d;
    logic               tx_q,    tx_d;
    logic               busy_q,  busy_d;
    logic               done_q,  done_d;
    logic               bit_end;

    // Next-state logic; outputs are computed from the next state so that the
    // registered line value changes on the same edge as the state.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        shift_d = shift_q;
        par_d   = par_q;
        bit_end = (cnt_q == C_CNT_LAST);

        // The baud counter free-runs inside a frame and wraps at each bit end,
        // which is exactly when every state/bit change happens.
        if (state_q != S_IDLE) begin
            cnt_d = bit_end ? '0 : cnt_q + 1'b1;
        end

        case (state_q)
            S_IDLE: begin
                if (valid) begin
                    state_d = S_START;
                    shift_d = data_in;
                    par_d   = 1'b0;
                    cnt_d   = '0;
                    idx_d   = '0;
                end
            end
            S_START: begin
                if (bit_end) begin
                    state_d = S_DATA;
                    idx_d   = '0;
                end
            end
            S_DATA: begin
                if (bit_end) begin
                    shift_d = shift_q >> 1;
                    par_d   = par_q ^ shift_q[0];
                    if (idx_q == C_IDX_LAST) begin
                        state_d = C_PAR_EN ? S_PARITY : S_STOP;
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end
            end
            S_PARITY: begin
                if (bit_end) begin
                    state_d = S_STOP;
                end
            end
            S_STOP: begin
                if (bit_end) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        case (state_d)
            S_START:  tx_d = 1'b0;
            S_DATA:   tx_d = shift_d[0];
            S_PARITY: tx_d = par_d ^ C_PAR_ODD;
            default:  tx_d = 1'b1;
        endcase

        busy_d = (state_d != S_IDLE);
        done_d = (state_d == S_STOP) && (cnt_d == C_CNT_LAST);
    end

    // State and output registers; reset aborts any frame and drives the line high.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            shift_q <= '0;
            par_q   <= 1'b0;
            tx_q    <= 1'b1;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            shift_q <= shift_d;
            par_q   <= par_d;
            tx_q    <= tx_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign ready = (state_q == S_IDLE);
    assign tx    = tx_q;
    assign busy  = busy_q;
    assign done  = done_q;

endmodule
`default_nettype wire

// File: tb/tb_serial_frame_tx.sv
`default_nettype none
// ============================================================================
// Module   : tb_serial_frame_tx
// Purpose  : Self-checking bench for serial_frame_tx. Four instances cover
//            default even parity, odd parity, no parity and one clock per bit.
// Revision : 1.0 - initial release
// ============================================================================
module tb_serial_frame_tx;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] valid_v = 4'b0;
    logic [7:0] din [4];
    wire  [3:0] tx_v, ready_v, busy_v, done_v;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    // Instance configurations: 0 default, 1 odd parity, 2 no parity, 3 fast/narrow
    serial_frame_tx #(.WIDTH(8), .CLKS_PER_BIT(4), .PARITY_EN(1), .PARITY_ODD(0)) u_def (
        .clk(clk), .rst(rst), .data_in(din[0]), .valid(valid_v[0]),
        .ready(ready_v[0]), .tx(tx_v[0]), .busy(busy_v[0]), .done(done_v[0]));
    serial_frame_tx #(.WIDTH(8), .CLKS_PER_BIT(4), .PARITY_EN(1), .PARITY_ODD(1)) u_odd (
        .clk(clk), .rst(rst), .data_in(din[1]), .valid(valid_v[1]),
        .ready(ready_v[1]), .tx(tx_v[1]), .busy(busy_v[1]), .done(done_v[1]));
    serial_frame_tx #(.WIDTH(8), .CLKS_PER_BIT(4), .PARITY_EN(0), .PARITY_ODD(0)) u_nop (
        .clk(clk), .rst(rst), .data_in(din[2]), .valid(valid_v[2]),
        .ready(ready_v[2]), .tx(tx_v[2]), .busy(busy_v[2]), .done(done_v[2]));
    serial_frame_tx #(.WIDTH(4), .CLKS_PER_BIT(1), .PARITY_EN(1), .PARITY_ODD(0)) u_fast (
        .clk(clk), .rst(rst), .data_in(din[3][3:0]), .valid(valid_v[3]),
        .ready(ready_v[3]), .tx(tx_v[3]), .busy(busy_v[3]), .done(done_v[3]));

    function automatic int p_w(input int k);   return (k == 3) ? 4 : 8; endfunction
    function automatic int p_cpb(input int k); return (k == 3) ? 1 : 4; endfunction
    function automatic int p_pen(input int k); return (k == 2) ? 0 : 1; endfunction
    function automatic int p_odd(input int k); return (k == 1) ? 1 : 0; endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
        end
    endtask

    // Send one word on instance k starting at a negedge with the DUT idle.
    // Expected line is built from the frame format: start, data LSB first,
    // optional parity, stop, each repeated CLKS_PER_BIT times.
    task automatic run_frame(input int k, input logic [7:0] d, input bit hold,
                             input logic [7:0] nxt, output int done_at, output logic par_seen);
        logic       bits_q[$];
        logic [7:0] dm;
        int         w, cpb, len, o;
        logic       pbit;
        w   = p_w(k);
        cpb = p_cpb(k);
        o   = p_odd(k);
        dm  = '0;
        for (int j = 0; j < w; j++) dm[j] = d[j];
        pbit = (^dm) ^ o[0];
        bits_q.push_back(1'b0);
        for (int j = 0; j < w; j++) bits_q.push_back(dm[j]);
        if (p_pen(k) != 0) bits_q.push_back(pbit);
        bits_q.push_back(1'b1);
        len      = bits_q.size() * cpb;
        done_at  = -1;
        par_seen = 1'b0;

        din[k]     = d;
        valid_v[k] = 1'b1;
        @(negedge clk);
        if (hold) begin
            din[k] = nxt;
        end else begin
            valid_v[k] = 1'b0;
            din[k]     = 8'($urandom);
        end
        for (int i = 0; i < len; i++) begin
            check($sformatf("frame k%0d d%0h i%0d {tx,busy,done,ready}", k, d, i),
                  32'({tx_v[k], busy_v[k], done_v[k], ready_v[k]}),
                  32'({bits_q[i / cpb], 1'b1, (i == len - 1), 1'b0}));
            if (done_v[k] && done_at < 0) done_at = i + 1;
            if (p_pen(k) != 0 && i == (1 + w) * cpb + cpb / 2) par_seen = tx_v[k];
            @(negedge clk);
        end
        check($sformatf("idle_after k%0d {tx,busy,done,ready}", k),
              32'({tx_v[k], busy_v[k], done_v[k], ready_v[k]}), 32'(4'b1001));
    endtask

    typedef struct {
        int         inst;
        logic [7:0] data;
        int         exp_len;
        logic       exp_par;
    } vec_t;

    vec_t vecs[4];

    initial begin
        int   dat;
        logic ps;
        for (int k = 0; k < 4; k++) din[k] = '0;

        vecs[0] = '{0, 8'hA5, 44, 1'b0};
        vecs[1] = '{1, 8'h07, 44, 1'b0};
        vecs[2] = '{2, 8'h07, 40, 1'b0};
        vecs[3] = '{3, 8'h09,  7, 1'b0};

        // Reset state and idle hold
        repeat (3) @(negedge clk);
        check("in_reset tx", 32'(tx_v), 32'(4'hF));
        check("in_reset busy", 32'(busy_v), 32'(4'h0));
        rst = 1'b0;
        for (int c = 0; c < 20; c++) begin
            check($sformatf("reset_idle c%0d", c),
                  32'({tx_v, busy_v, done_v, ready_v}), 32'({4'hF, 4'h0, 4'h0, 4'hF}));
            @(negedge clk);
        end

        // Directed frame table
        for (int v = 0; v < 4; v++) begin
            run_frame(vecs[v].inst, vecs[v].data, 1'b0, 8'h00, dat, ps);
            check($sformatf("frame_len v%0d", v), 32'(dat), 32'(vecs[v].exp_len));
            if (p_pen(vecs[v].inst) != 0)
                check($sformatf("parity_bit v%0d", v), 32'(ps), 32'(vecs[v].exp_par));
            @(negedge clk);
        end

        // Back-to-back with valid held high; data changes mid-frame
        run_frame(0, 8'h3C, 1'b1, 8'hC3, dat, ps);
        run_frame(0, 8'hC3, 1'b0, 8'h00, dat, ps);
        check("b2b second len", 32'(dat), 32'd44);
        @(negedge clk);

        // Reset during DATA bit 3 of 8'hFF
        din[0]     = 8'hFF;
        valid_v[0] = 1'b1;
        @(negedge clk);
        valid_v[0] = 1'b0;
        repeat (17) @(negedge clk);
        check("pre_reset busy", 32'(busy_v[0]), 32'd1);
        rst = 1'b1;
        #1;
        check("async_reset {tx,busy,done,ready}",
              32'({tx_v[0], busy_v[0], done_v[0], ready_v[0]}), 32'(4'b1001));
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            check("reset_hold done", 32'(done_v), 32'd0);
        end
        rst = 1'b0;
        @(negedge clk);
        run_frame(0, 8'h01, 1'b0, 8'h00, dat, ps);
        check("post_reset len", 32'(dat), 32'd44);
        @(negedge clk);

        // Randomized frames against the reference frame builder
        repeat (40) begin
            int k;
            k = int'($urandom_range(0, 3));
            run_frame(k, 8'($urandom), 1'b0, 8'h00, dat, ps);
            @(negedge clk);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    // Absolute time bound so the run always terminates
    initial begin
        #500000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
